fb_writer: RTL
==============

FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter WE_CYCLES, default 2, number of clk cycles ram_we is held low per write (legal 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all logic rises on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1  single-word write request valid.
REQ-006 SHALL have port wr_ready  output  1  request accepted when wr_valid && wr_ready.
REQ-007 SHALL have port wr_addr  input  ADDR_W  word address of request.
REQ-008 SHALL have port wr_data  input  16  write data.
REQ-009 SHALL have port wr_be  input  2  byte enables: bit0 low byte, bit1 high byte.
REQ-010 SHALL have port fill_start  input  1  one-cycle pulse starting a fill.
REQ-011 SHALL have port fill_addr / fill_count / fill_data  input  ADDR_W / ADDR_W / 16  fill base, word count (0 = no-op), pattern.
REQ-012 SHALL have port bus_req  output  1  writer requests the SRAM bus.
REQ-013 SHALL have port bus_grant  input  1  arbiter grants bus; the background reader owns it otherwise.
REQ-014 SHALL have port busy  output  1  high while any write or fill is pending or in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at completion of a single write or a whole fill.
REQ-016 SHALL have ports ram_addr (ADDR_W), ram_dout (16), ram_drive (1), ram_ce, ram_oe, ram_we, ram_lb, ram_hb (1 each), all outputs; ram_ce/oe/we/lb/hb are active-low.

Function
REQ-017 SHALL implement states IDLE, WAIT_GRANT, SETUP, STROBE, HOLD.
REQ-018 IDLE: wr_ready=1; single-write acceptance latches addr/data/be and goes to WAIT_GRANT; fill_start with fill_count!=0 latches fill registers and goes to WAIT_GRANT; fill_count=0 pulses done next cycle and stays IDLE.
REQ-019 Simultaneous fill_start and accepted wr_valid in IDLE: the single write SHALL win; fill_start is ignored.
REQ-020 fill_start and wr_valid outside IDLE SHALL be ignored; wr_ready=0 outside IDLE.
REQ-021 WAIT_GRANT: bus_req=1; on bus_grant=1 go to SETUP; otherwise remain.
REQ-022 SETUP (1 cycle): ram_ce=0, ram_oe=1, ram_we=1, ram_drive=1, ram_addr/ram_dout/lb/hb valid.
REQ-023 STROBE: ram_we=0 for exactly WE_CYCLES cycles, address, data and byte lanes stable.
REQ-024 HOLD (1 cycle): ram_we=1, ram_drive=1, address and data unchanged.
REQ-025 After HOLD, single write or last fill word: done=1 for one cycle, go to IDLE, bus_req=0.
REQ-026 After HOLD, fill words remaining: decrement count, increment address modulo 2^ADDR_W (max wraps to 0), return to WAIT_GRANT if bus_grant=0, else SETUP.
REQ-027 Fill writes SHALL use lb=hb=0 (both bytes); single writes SHALL drive ram_lb=~wr_be[0], ram_hb=~wr_be[1]; wr_be=00 SHALL still run the cycle with both lanes disabled.
REQ-028 bus_grant deasserting during SETUP/STROBE/HOLD SHALL NOT abort the current word; re-checked only before next SETUP.
REQ-029 Outside SETUP/STROBE/HOLD: ram_ce=ram_oe=ram_we=ram_lb=ram_hb=1, ram_drive=0.
REQ-030 busy SHALL be 0 only in IDLE.
REQ-031 All SRAM outputs SHALL be registered (no combinational path from inputs).
REQ-032 Word throughput SHALL be WE_CYCLES+2 clk per word with grant held.

Reset
REQ-033 reset SHALL force IDLE; wr_ready=1 the cycle after reset releases, bus_req=0, busy=0, done=0, ram_drive=0, ram_ce/oe/we/lb/hb=1, ram_addr=0, ram_dout=0.
REQ-034 reset during STROBE SHALL release ram_we high on the next clock; the interrupted fill is discarded and no done pulse is produced.

Structure
REQ-035 State encoding and the SRAM control idle value SHALL live in shared package fb_pkg, reused by the background reader.
REQ-036 A sub-module fb_write_cycle (SETUP/STROBE/HOLD timing) SHALL be used; fill sequencing stays in fb_writer.

Verification
REQ-037 Single write addr=0x00010, data=0xBEEF, be=11, grant=1 -> one ram_we low pulse of 2 cycles, lb=hb=0, done 5 cycles after acceptance.
REQ-038 be=01 write data=0x1234 -> ram_lb=0, ram_hb=1 throughout STROBE; SRAM model high byte unchanged.
REQ-039 Fill addr=0x3FFFE, count=4, data=0x0000 -> writes to 0x3FFFE, 0x3FFFF, 0x00000, 0x00001, one done pulse at end.
REQ-040 Grant drops during second fill word STROBE -> that word completes, bus_req stays 1, third word waits in WAIT_GRANT until grant returns.
REQ-041 reset asserted mid-STROBE of a 100-word fill -> ram_we=1 next cycle, busy=0, no done, later single write works normally.
REQ-042 fill_count=0 -> done pulse, no SRAM activity, bus_req never asserted.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer SRAM definitions: sequencer state encoding and the
// inactive value of the active-low SRAM control pins.
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    SETUP,
    STROBE,
    HOLD
  } fb_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic hb_n;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                          lb_n: 1'b1, hb_n: 1'b1};

  function automatic logic is_cycle_state(input fb_state_t s);
    return (s == SETUP) || (s == STROBE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/fb_write_cycle.sv
// One SRAM word write: SETUP, WE_CYCLES of STROBE, HOLD. Every pin is a flop
// loaded from the next phase, so the pins change exactly on phase entry.
module fb_write_cycle
  import fb_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data,
  input  logic              lb_n,
  input  logic              hb_n,
  output logic              hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dout,
  output logic              ram_drive,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_lb,
  output logic              ram_hb
);

  localparam logic [3:0] STROBE_LAST = 4'(WE_CYCLES - 1);

  fb_state_t phase_q, phase_d;
  logic [3:0] cnt_q, cnt_d;
  sram_ctl_t ctl_q, ctl_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      IDLE:    if (start) phase_d = SETUP;
      SETUP: begin
        phase_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) phase_d = HOLD;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      HOLD:    phase_d = start ? SETUP : IDLE;
      default: phase_d = IDLE;
    endcase

    ctl_d = SRAM_CTL_IDLE;
    if (is_cycle_state(phase_d)) begin
      ctl_d.ce_n = 1'b0;
      ctl_d.we_n = (phase_d != STROBE);
      // byte lanes are captured on SETUP entry and held for the rest of the word
      ctl_d.lb_n = (phase_d == SETUP) ? lb_n : ctl_q.lb_n;
      ctl_d.hb_n = (phase_d == SETUP) ? hb_n : ctl_q.hb_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= IDLE;
      cnt_q     <= '0;
      ctl_q     <= SRAM_CTL_IDLE;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_drive <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ctl_q     <= ctl_d;
      ram_drive <= is_cycle_state(phase_d);
      if (phase_d == SETUP) begin
        ram_addr <= addr;
        ram_dout <= data;
      end
    end
  end

  assign hold   = (phase_q == HOLD);
  assign ram_ce = ctl_q.ce_n;
  assign ram_oe = ctl_q.oe_n;
  assign ram_we = ctl_q.we_n;
  assign ram_lb = ctl_q.lb_n;
  assign ram_hb = ctl_q.hb_n;

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer SRAM writer: single byte-masked writes and constant-pattern
// fills, arbitrating for the bus word by word against the background reader.
module fb_writer
  import fb_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_be,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] fill_count,
  input  logic [15:0]       fill_data,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dout,
  output logic              ram_drive,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_lb,
  output logic              ram_hb
);

  // ctl_q == SETUP stands for the whole word cycle; fb_write_cycle owns the
  // SETUP/STROBE/HOLD split and reports HOLD back so the next word can chain.
  fb_state_t ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic lb_q, lb_d, hb_q, hb_d, fill_q, fill_d;
  logic done_d, start, hold;

  always_comb begin
    ctl_d  = ctl_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    lb_d   = lb_q;
    hb_d   = hb_q;
    fill_d = fill_q;
    done_d = 1'b0;
    start  = 1'b0;
    case (ctl_q)
      IDLE: begin
        if (wr_valid) begin
          addr_d = wr_addr;
          data_d = wr_data;
          lb_d   = ~wr_be[0];
          hb_d   = ~wr_be[1];
          fill_d = 1'b0;
          ctl_d  = WAIT_GRANT;
        end else if (fill_start) begin
          if (fill_count != '0) begin
            addr_d = fill_addr;
            cnt_d  = fill_count;
            data_d = fill_data;
            lb_d   = 1'b0;
            hb_d   = 1'b0;
            fill_d = 1'b1;
            ctl_d  = WAIT_GRANT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_GRANT: begin
        if (bus_grant) begin
          start = 1'b1;
          ctl_d = SETUP;
        end
      end
      SETUP: begin
        if (hold) begin
          if (!fill_q || cnt_q == ADDR_W'(1)) begin
            done_d = 1'b1;
            ctl_d  = IDLE;
          end else begin
            cnt_d  = cnt_q - ADDR_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            if (bus_grant) start = 1'b1;
            else           ctl_d = WAIT_GRANT;
          end
        end
      end
      default: ctl_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q  <= IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      lb_q   <= 1'b1;
      hb_q   <= 1'b1;
      fill_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      lb_q   <= lb_d;
      hb_q   <= hb_d;
      fill_q <= fill_d;
      done   <= done_d;
    end
  end

  assign wr_ready = (ctl_q == IDLE);
  assign bus_req  = (ctl_q != IDLE);
  assign busy     = (ctl_q != IDLE);

  fb_write_cycle #(
    .ADDR_W   (ADDR_W),
    .WE_CYCLES(WE_CYCLES)
  ) u_cycle (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr     (addr_d),
    .data     (data_d),
    .lb_n     (lb_d),
    .hb_n     (hb_d),
    .hold     (hold),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_drive(ram_drive),
    .ram_ce   (ram_ce),
    .ram_oe   (ram_oe),
    .ram_we   (ram_we),
    .ram_lb   (ram_lb),
    .ram_hb   (ram_hb)
  );

endmodule
